// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN stack calculator.
// Holds the one-hot state encoding, opcode encoding and flag bit positions.
package rpn_pkg;

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        PUSH    = 6'b000010,
        OP_READ = 6'b000100,
        OP_EXEC = 6'b001000,
        OP_WB   = 6'b010000,
        ERROR   = 6'b100000
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_OR  = 2'b10,
        OP_AND = 2'b11
    } opcode_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/rpn_operand_stack.sv
// Operand stack: register array with one write port, asynchronous reads of the
// top two entries, and a depth counter with increment/decrement/clear.
module rpn_operand_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       inc_i,
    input  logic                       dec_i,
    output logic [WIDTH-1:0]           top_o,
    output logic [WIDTH-1:0]           next_o,
    output logic [$clog2(DEPTH+1)-1:0] depth_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    depth_d;
    logic [AW-1:0]    top_idx_s;
    logic [AW-1:0]    next_idx_s;

    // Depth counter next-state: clear wins, then increment, then decrement.
    always_comb begin
        depth_d = depth_q;
        if (clr_i) begin
            depth_d = {DW{1'b0}};
        end else if (inc_i) begin
            depth_d = depth_q + DW'(1);
        end else if (dec_i) begin
            depth_d = depth_q - DW'(1);
        end else begin
            depth_d = depth_q;
        end
    end

    // Depth counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= {DW{1'b0}};
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry storage; contents are meaningless above the current depth.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Index arithmetic wraps modulo DEPTH, so a full stack reads entry DEPTH-1.
    assign top_idx_s  = depth_q[AW-1:0] - AW'(1);
    assign next_idx_s = depth_q[AW-1:0] - AW'(2);
    assign top_o      = mem_q[top_idx_s];
    assign next_o     = mem_q[next_idx_s];
    assign depth_o    = depth_q;

endmodule

// File: rtl/rpn_stack_calculator.sv
// Reverse-Polish calculator controller: push/operate commands drive a small
// operand stack through a one-hot FSM with a registered ALU stage.
module rpn_stack_calculator
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       PushEnter,
    input  logic                       OpEnter,
    input  logic                       Clear,
    input  logic [WIDTH-1:0]           DataIn,
    output logic [WIDTH-1:0]           DataOut,
    output logic [$clog2(DEPTH+1)-1:0] Depth,
    output logic [3:0]                 Flags,
    output logic                       Busy,
    output logic                       Error,
    output logic [5:0]                 CurrentState
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);

    state_t           state_q, state_d;
    opcode_t          op_q;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       nflags_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH+3:0] alu_s;

    logic             stk_clr_s, stk_wr_s, stk_inc_s, stk_dec_s;
    logic [AW-1:0]    stk_addr_s;
    logic [WIDTH-1:0] stk_wdata_s, stk_top_s, stk_next_s;
    logic [DW-1:0]    depth_s;

    // Returns {flags, result}; subtraction is A + ~B + 1 so C means no borrow.
    function automatic logic [WIDTH+3:0] alu(input opcode_t op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] r;
        logic [3:0]       f;
        sum = {(WIDTH+1){1'b0}};
        bx  = b;
        r   = {WIDTH{1'b0}};
        f   = 4'b0000;
        case (op)
            OP_ADD: begin
                sum       = {1'b0, a} + {1'b0, bx};
                r         = sum[WIDTH-1:0];
                f[FLAG_C] = sum[WIDTH];
                f[FLAG_V] = (a[WIDTH-1] == bx[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                bx        = ~b;
                sum       = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, 1'b1};
                r         = sum[WIDTH-1:0];
                f[FLAG_C] = sum[WIDTH];
                f[FLAG_V] = (a[WIDTH-1] == bx[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            default: r = {WIDTH{1'b0}};
        endcase
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_Z] = (r == {WIDTH{1'b0}});
        return {f, r};
    endfunction

    rpn_operand_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (stk_clr_s),
        .wr_en_i   (stk_wr_s),
        .wr_addr_i (stk_addr_s),
        .wr_data_i (stk_wdata_s),
        .inc_i     (stk_inc_s),
        .dec_i     (stk_dec_s),
        .top_o     (stk_top_s),
        .next_o    (stk_next_s),
        .depth_o   (depth_s)
    );

    assign alu_s = alu(op_q, a_q, b_q);

    // Next-state and stack control; Clear aborts any operation in flight.
    always_comb begin
        state_d     = state_q;
        stk_clr_s   = 1'b0;
        stk_wr_s    = 1'b0;
        stk_inc_s   = 1'b0;
        stk_dec_s   = 1'b0;
        stk_addr_s  = {AW{1'b0}};
        stk_wdata_s = {WIDTH{1'b0}};
        if (Clear) begin
            state_d   = IDLE;
            stk_clr_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (PushEnter) begin
                        state_d = (depth_s == DW'(DEPTH)) ? ERROR : PUSH;
                    end else if (OpEnter) begin
                        state_d = (depth_s < DW'(2)) ? ERROR : OP_READ;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PUSH: begin
                    stk_wr_s    = 1'b1;
                    stk_addr_s  = depth_s[AW-1:0];
                    stk_wdata_s = in_q;
                    stk_inc_s   = 1'b1;
                    state_d     = IDLE;
                end
                OP_READ: state_d = OP_EXEC;
                OP_EXEC: state_d = OP_WB;
                OP_WB: begin
                    stk_wr_s    = 1'b1;
                    stk_addr_s  = depth_s[AW-1:0] - AW'(2);
                    stk_wdata_s = res_q;
                    stk_dec_s   = 1'b1;
                    state_d     = IDLE;
                end
                ERROR: begin
                    if (PushEnter || OpEnter) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ERROR;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, operand capture, ALU pipeline and visible output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            in_q     <= {WIDTH{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            res_q    <= {WIDTH{1'b0}};
            nflags_q <= 4'b0000;
            flags_q  <= 4'b0000;
            dout_q   <= {WIDTH{1'b0}};
        end else if (Clear) begin
            state_q <= IDLE;
            flags_q <= 4'b0000;
            dout_q  <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (PushEnter) begin
                        in_q <= DataIn;
                    end else if (OpEnter) begin
                        op_q <= opcode_t'(DataIn[1:0]);
                    end
                end
                PUSH:    dout_q <= in_q;
                OP_READ: begin
                    a_q <= stk_next_s;
                    b_q <= stk_top_s;
                end
                OP_EXEC: begin
                    res_q    <= alu_s[WIDTH-1:0];
                    nflags_q <= alu_s[WIDTH+3:WIDTH];
                end
                OP_WB: begin
                    dout_q  <= res_q;
                    flags_q <= nflags_q;
                end
                default: ;
            endcase
        end
    end

    assign DataOut      = dout_q;
    assign Depth        = depth_s;
    assign Flags        = flags_q;
    assign Busy         = !((state_q == IDLE) || (state_q == ERROR));
    assign Error        = (state_q == ERROR);
    assign CurrentState = state_q;

endmodule

// File: tb/tb_rpn_stack_calculator.sv
// Self-checking bench: directed scenarios plus random commands compared against
// a queue-based reference model of the calculator.
module tb_rpn_stack_calculator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PushEnter = 1'b0;
    logic        OpEnter = 1'b0;
    logic        Clear = 1'b0;
    logic [15:0] DataIn = 16'h0000;
    logic [15:0] DataOut;
    logic [2:0]  Depth;
    logic [3:0]  Flags;
    logic        Busy;
    logic        Error;
    logic [5:0]  CurrentState;

    int checks = 0;
    int errors = 0;

    logic [15:0] mq[$];
    logic [3:0]  mflags = 4'b0000;
    logic        merr = 1'b0;

    rpn_stack_calculator #(.WIDTH(16), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .PushEnter    (PushEnter),
        .OpEnter      (OpEnter),
        .Clear        (Clear),
        .DataIn       (DataIn),
        .DataOut      (DataOut),
        .Depth        (Depth),
        .Flags        (Flags),
        .Busy         (Busy),
        .Error        (Error),
        .CurrentState (CurrentState)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] top;
        top = (mq.size() == 0) ? 16'h0000 : mq[mq.size()-1];
        chk({tag, ".DataOut"}, {16'h0000, DataOut}, {16'h0000, top});
        chk({tag, ".Depth"}, {29'h0, Depth}, mq.size());
        chk({tag, ".Flags"}, {28'h0, Flags}, {28'h0, mflags});
        chk({tag, ".Error"}, {31'h0, Error}, {31'h0, merr});
        chk({tag, ".Busy"}, {31'h0, Busy}, 32'h0);
    endtask

    // Reference arithmetic from the opcode definitions, using signed/unsigned ints.
    task automatic model_op(input int op);
        int a, b, sa, sb, r, s;
        logic c, v;
        b = int'(mq.pop_back());
        a = int'(mq.pop_back());
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        c = 1'b0;
        v = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 65535); s = sa + sb; v = (s > 32767) || (s < -32768); end
            1: begin r = a - b; c = (a >= b);    s = sa - sb; v = (s > 32767) || (s < -32768); end
            2: r = a | b;
            default: r = a & b;
        endcase
        r = r & 32'hFFFF;
        mflags = {(r >= 32768), (r == 0), c, v};
        mq.push_back(16'(r));
    endtask

    task automatic do_push(input logic [15:0] v);
        PushEnter = 1'b1;
        DataIn = v;
        tick();
        PushEnter = 1'b0;
        tick();
        if (merr) merr = 1'b0;
        else if (mq.size() == 4) merr = 1'b1;
        else mq.push_back(v);
    endtask

    task automatic do_op(input int op, input string tag);
        logic exec;
        exec = !merr && (mq.size() >= 2);
        OpEnter = 1'b1;
        DataIn = 16'(op);
        tick();
        OpEnter = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({tag, ".Busy"}, {31'h0, Busy}, {31'h0, exec});
            if (exec && i == 0) begin
                PushEnter = 1'b1;
                DataIn = 16'hBEEF;
            end
            tick();
            PushEnter = 1'b0;
        end
        if (merr) merr = 1'b0;
        else if (mq.size() < 2) merr = 1'b1;
        else model_op(op);
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        mq.delete();
        mflags = 4'b0000;
        merr = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("reset.state", {26'h0, CurrentState}, 32'h1);
        check_model("reset");

        do_push(16'd5); do_push(16'd3);
        chk("add.push_visible", {16'h0, DataOut}, 32'h3);
        do_op(0, "add");
        check_model("add");
        chk("add.value", {16'h0, DataOut}, 32'h8);

        do_clear();
        do_push(16'd3); do_push(16'd5); do_op(1, "sub1");
        check_model("sub1");
        chk("sub1.flags", {28'h0, Flags}, 32'h8);
        do_push(16'hFFFE); do_op(1, "sub2");
        check_model("sub2");
        chk("sub2.flags", {28'h0, Flags}, 32'h6);

        do_clear();
        do_push(16'h7FFF); do_push(16'h0001); do_op(0, "ovf");
        check_model("ovf");
        chk("ovf.flags", {28'h0, Flags}, 32'h9);
        do_push(16'hFFFF); do_op(3, "and");
        check_model("and");

        do_clear();
        do_push(16'd1); do_push(16'd2); do_push(16'd3); do_push(16'd4);
        do_push(16'd9);
        check_model("full");
        chk("full.error", {31'h0, Error}, 32'h1);
        do_op(0, "full_op");
        check_model("full_op");

        do_clear();
        do_push(16'd7); do_op(0, "under");
        check_model("under");
        chk("under.error", {31'h0, Error}, 32'h1);

        do_clear();
        do_push(16'd2); do_push(16'd6);
        OpEnter = 1'b1; DataIn = 16'h0000;
        tick();
        OpEnter = 1'b0;
        tick();
        chk("clr.in_exec", {26'h0, CurrentState}, 32'h8);
        do_clear();
        chk("clr.state", {26'h0, CurrentState}, 32'h1);
        check_model("clr");
        tick(); tick();
        check_model("clr.no_wb");

        do_push(16'd1); do_push(16'd2);
        PushEnter = 1'b1; OpEnter = 1'b1; DataIn = 16'h0000;
        tick();
        PushEnter = 1'b0; OpEnter = 1'b0;
        tick();
        mq.push_back(16'h0000);
        check_model("both");

        for (int n = 0; n < 300; n++) begin
            int sel;
            logic [15:0] v;
            sel = int'($urandom_range(0, 11));
            if (sel < 5) begin
                case ($urandom_range(0, 3))
                    0: v = 16'h7FFF;
                    1: v = 16'h8000;
                    2: v = 16'hFFFF;
                    default: v = 16'($urandom);
                endcase
                do_push(v);
            end else if (sel < 11) begin
                do_op(int'($urandom_range(0, 3)), "rnd_op");
            end else begin
                do_clear();
            end
            check_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
